// File: rtl/jtcontra_colmix.sv
// rtl/jtcontra_colmix.sv - colour mixer for two 007121 layers with CPU palette RAM
//
// Purpose: resolves priority/transparency between chip A and chip B pixels,
// looks the winner up in a 256 x 15-bit palette and drives 5-bit RGB, with
// the blanking signals delayed to match the two-tick colour pipeline.
//
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   pxl_cen             pixel clock enable; every pixel stage advances on it
//   LHBL, LVBL          active-low blanking, aligned with pxl_a/pxl_b
//   cpu_cen, pal_cs,
//   cpu_rnw, cpu_addr,
//   cpu_dout, pal_dout  CPU byte port of the palette RAM (addr[0] = high byte)
//   gfx_en              per-chip layer enables, prio = chip B over chip A
//   pxl_a, pxl_b        {palette[3:0], pen[3:0]} from each chip
//   red, green, blue    5-bit colour output
//   LHBL_dly, LVBL_dly  blanking delayed by LATENCY pixel ticks
module jtcontra_colmix #(
  parameter int LATENCY = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pxl_cen,
  input  logic       LHBL,
  input  logic       LVBL,
  input  logic       cpu_cen,
  input  logic       pal_cs,
  input  logic       cpu_rnw,
  input  logic [8:0] cpu_addr,
  input  logic [7:0] cpu_dout,
  output logic [7:0] pal_dout,
  input  logic [1:0] gfx_en,
  input  logic       prio,
  input  logic [7:0] pxl_a,
  input  logic [7:0] pxl_b,
  output logic [4:0] red,
  output logic [4:0] green,
  output logic [4:0] blue,
  output logic       LHBL_dly,
  output logic       LVBL_dly
);

  // Palette kept as two byte lanes so the CPU can write single bytes.
  logic [7:0] pal_lo [256];
  logic [7:0] pal_hi [256];

  logic        opaque_a;
  logic        opaque_b;
  logic        sel_a;
  logic [7:0]  pal_idx;

  logic [7:0]  idx_s1;
  logic        lhbl_s1;
  logic        lvbl_s1;
  logic [14:0] pal_q;

  // Bit 7 of each chip pixel is not part of the colour; the top index bit
  // comes from the chip selection instead. LATENCY is fixed by construction.
  logic unused_bits;
  assign unused_bits = ^{pxl_a[7], pxl_b[7], LATENCY[0]};

  always_ff @(posedge clk) begin
    if (cpu_cen && pal_cs && !cpu_rnw) begin
      if (cpu_addr[0]) pal_hi[cpu_addr[8:1]] <= cpu_dout;
      else             pal_lo[cpu_addr[8:1]] <= cpu_dout;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) pal_dout <= 8'd0;
    else     pal_dout <= cpu_addr[0] ? pal_hi[cpu_addr[8:1]] : pal_lo[cpu_addr[8:1]];
  end

  // Chip B wins whenever A is not shown, so B pen 0 becomes the backdrop.
  always_comb begin
    opaque_a = gfx_en[0] && (pxl_a[3:0] != 4'd0);
    opaque_b = gfx_en[1] && (pxl_b[3:0] != 4'd0);
    sel_a    = opaque_a && (!prio || !opaque_b);
    pal_idx  = sel_a ? {1'b0, pxl_a[6:0]} : {1'b1, pxl_b[6:0]};
  end

  // The video read runs every clk on the stage-1 index. A CPU write on the
  // same edge is not seen by pal_q until the following clk (read-before-write).
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_s1   <= 8'd0;
      lhbl_s1  <= 1'b0;
      lvbl_s1  <= 1'b0;
      pal_q    <= 15'd0;
      red      <= 5'd0;
      green    <= 5'd0;
      blue     <= 5'd0;
      LHBL_dly <= 1'b0;
      LVBL_dly <= 1'b0;
    end else begin
      pal_q <= {pal_hi[idx_s1][6:0], pal_lo[idx_s1]};
      if (pxl_cen) begin
        idx_s1   <= pal_idx;
        lhbl_s1  <= LHBL;
        lvbl_s1  <= LVBL;
        LHBL_dly <= lhbl_s1;
        LVBL_dly <= lvbl_s1;
        if (lhbl_s1 && lvbl_s1) begin
          red   <= pal_q[4:0];
          green <= pal_q[9:5];
          blue  <= pal_q[14:10];
        end else begin
          red   <= 5'd0;
          green <= 5'd0;
          blue  <= 5'd0;
        end
      end
    end
  end

endmodule

// File: tb/tb_jtcontra_colmix.sv
// tb/tb_jtcontra_colmix.sv - directed self-checking bench for jtcontra_colmix
module tb_jtcontra_colmix;

  logic       clk;
  logic       rst;
  logic       pxl_cen;
  logic       LHBL;
  logic       LVBL;
  logic       cpu_cen;
  logic       pal_cs;
  logic       cpu_rnw;
  logic [8:0] cpu_addr;
  logic [7:0] cpu_dout;
  logic [7:0] pal_dout;
  logic [1:0] gfx_en;
  logic       prio;
  logic [7:0] pxl_a;
  logic [7:0] pxl_b;
  logic [4:0] red;
  logic [4:0] green;
  logic [4:0] blue;
  logic       LHBL_dly;
  logic       LVBL_dly;

  int checks = 0;
  int fails  = 0;

  jtcontra_colmix #(.LATENCY(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .pxl_cen  (pxl_cen),
    .LHBL     (LHBL),
    .LVBL     (LVBL),
    .cpu_cen  (cpu_cen),
    .pal_cs   (pal_cs),
    .cpu_rnw  (cpu_rnw),
    .cpu_addr (cpu_addr),
    .cpu_dout (cpu_dout),
    .pal_dout (pal_dout),
    .gfx_en   (gfx_en),
    .prio     (prio),
    .pxl_a    (pxl_a),
    .pxl_b    (pxl_b),
    .red      (red),
    .green    (green),
    .blue     (blue),
    .LHBL_dly (LHBL_dly),
    .LVBL_dly (LVBL_dly)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL timeout obs=running exp=finished");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One pixel tick: an edge with pxl_cen high followed by one with it low.
  task automatic pix_tick();
    pxl_cen = 1'b1;
    step();
    pxl_cen = 1'b0;
    step();
  endtask

  task automatic cpu_wr(input logic [8:0] addr, input logic [7:0] data);
    cpu_cen  = 1'b1;
    pal_cs   = 1'b1;
    cpu_rnw  = 1'b0;
    cpu_addr = addr;
    cpu_dout = data;
    step();
    cpu_cen  = 1'b0;
    pal_cs   = 1'b0;
    cpu_rnw  = 1'b1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic check_rgb(input string tag, input logic [4:0] r, input logic [4:0] g, input logic [4:0] b);
    check(tag, {1'b0, red, green, blue}, {1'b0, r, g, b});
  endtask

  initial begin
    rst = 1'b1; pxl_cen = 1'b0; LHBL = 1'b1; LVBL = 1'b1;
    cpu_cen = 1'b0; pal_cs = 1'b0; cpu_rnw = 1'b1; cpu_addr = 9'd0; cpu_dout = 8'd0;
    gfx_en = 2'b11; prio = 1'b0; pxl_a = 8'h00; pxl_b = 8'h00;
    step();
    step();
    check_rgb("reset_rgb", 5'h00, 5'h00, 5'h00);
    check("reset_dly", {14'd0, LHBL_dly, LVBL_dly}, 16'd0);
    check("reset_pal_dout", {8'd0, pal_dout}, 16'd0);
    rst = 1'b0;

    // Palette: entry 0x01 = 0x7C1F, entry 0x85 = 0x03E0, entry 0x80 = 0x0011
    cpu_wr(9'h002, 8'h1F);
    cpu_wr(9'h003, 8'h7C);
    cpu_wr(9'h10A, 8'hE0);
    cpu_wr(9'h10B, 8'h03);
    cpu_wr(9'h100, 8'h11);
    cpu_wr(9'h101, 8'h00);

    pal_cs = 1'b1; cpu_rnw = 1'b1; cpu_addr = 9'h002;
    step();
    check("read_lo", {8'd0, pal_dout}, 16'h001F);
    cpu_addr = 9'h003;
    step();
    check("read_hi", {8'd0, pal_dout}, 16'h007C);
    pal_cs = 1'b0;

    // A over transparent B
    pxl_a = 8'h01; pxl_b = 8'h00; prio = 1'b0; gfx_en = 2'b11;
    pix_tick();
    pix_tick();
    check_rgb("a_over_b", 5'h1F, 5'h00, 5'h1F);
    check("blank_dly_high", {14'd0, LHBL_dly, LVBL_dly}, 16'd3);

    // Priority
    pxl_b = 8'h05; prio = 1'b1;
    pix_tick();
    pix_tick();
    check_rgb("prio_b", 5'h00, 5'h1F, 5'h00);
    prio = 1'b0;
    pix_tick();
    pix_tick();
    check_rgb("prio_a", 5'h1F, 5'h00, 5'h1F);
    prio = 1'b1; pxl_b = 8'h00;
    pix_tick();
    pix_tick();
    check_rgb("prio_b_transparent", 5'h1F, 5'h00, 5'h1F);
    prio = 1'b0;

    // Both transparent and layer disable
    pxl_a = 8'h00; pxl_b = 8'h00;
    pix_tick();
    pix_tick();
    check_rgb("both_transparent", 5'h11, 5'h00, 5'h00);
    gfx_en = 2'b10; pxl_a = 8'h01;
    pix_tick();
    pix_tick();
    check_rgb("a_disabled", 5'h11, 5'h00, 5'h00);
    gfx_en = 2'b11; pxl_a = 8'h81;
    pix_tick();
    pix_tick();
    check_rgb("bit7_ignored", 5'h1F, 5'h00, 5'h1F);

    // No pxl_cen: outputs hold
    pxl_a = 8'h00; pxl_b = 8'h05; prio = 1'b1;
    for (int i = 0; i < 4; i++) step();
    check_rgb("hold_no_cen", 5'h1F, 5'h00, 5'h1F);

    // Blanking pulses
    pxl_a = 8'h01; pxl_b = 8'h00; prio = 1'b0;
    pix_tick();
    pix_tick();
    LHBL = 1'b0;
    pix_tick();
    check_rgb("lhbl_before", 5'h1F, 5'h00, 5'h1F);
    LHBL = 1'b1;
    pix_tick();
    check_rgb("lhbl_rgb_blank", 5'h00, 5'h00, 5'h00);
    check("lhbl_dly_low", {14'd0, LHBL_dly, LVBL_dly}, 16'd1);
    pix_tick();
    check_rgb("lhbl_after", 5'h1F, 5'h00, 5'h1F);
    check("lhbl_dly_back", {14'd0, LHBL_dly, LVBL_dly}, 16'd3);
    LVBL = 1'b0;
    pix_tick();
    LVBL = 1'b1;
    pix_tick();
    check_rgb("lvbl_rgb_blank", 5'h00, 5'h00, 5'h00);
    check("lvbl_dly_low", {14'd0, LHBL_dly, LVBL_dly}, 16'd2);
    pix_tick();
    check_rgb("lvbl_after", 5'h1F, 5'h00, 5'h1F);

    // Collision: rewrite low byte of entry 0x01 while it is displayed
    pxl_cen = 1'b1;
    step();
    pxl_cen = 1'b0;
    cpu_wr(9'h002, 8'h00);
    pix_tick();
    check_rgb("collision_old", 5'h1F, 5'h00, 5'h1F);
    pix_tick();
    check_rgb("collision_new", 5'h00, 5'h00, 5'h1F);

    // Reset mid-stream
    rst = 1'b1;
    step();
    check_rgb("midreset_rgb", 5'h00, 5'h00, 5'h00);
    check("midreset_dly", {14'd0, LHBL_dly, LVBL_dly}, 16'd0);
    rst = 1'b0;
    pix_tick();
    pix_tick();
    check_rgb("refill_rgb", 5'h00, 5'h00, 5'h1F);
    check("refill_dly", {14'd0, LHBL_dly, LVBL_dly}, 16'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
